// File: rtl/prefetch_request_queue.sv
// prefetch_request_queue
// Front end of the lower-level cache for block prefetches. Requests arrive over
// a valid/ready handshake. Each one is block-aligned, de-duplicated against the
// live queue contents and against a concurrent demand miss, then buffered in a
// circular FIFO. Queued entries are cancelled by demand misses to the same
// block, and dead entries drain silently from the head. Live heads are issued
// to memory, subject to a cap on outstanding (issued but not yet filled)
// prefetches.

module prefetch_request_queue #(
  parameter int WIDTH           = 64,
  parameter int DEPTH           = 8,
  parameter int BLOCK_OFFSET    = 6,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         pf_addr_i,
  input  logic                     pf_valid_i,
  output logic                     pf_ready_o,
  input  logic                     demand_valid_i,
  input  logic [WIDTH-1:0]         demand_addr_i,
  output logic                     mem_req_valid_o,
  output logic [WIDTH-1:0]         mem_req_addr_o,
  input  logic                     mem_req_ready_i,
  input  logic                     mem_resp_valid_i,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [15:0]              pf_accepted_cnt_o,
  output logic [15:0]              pf_dropped_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  // Clear the byte-offset bits so that every address names a whole cache block.
  function automatic logic [WIDTH-1:0] blk(input logic [WIDTH-1:0] a);
    blk = {a[WIDTH-1:BLOCK_OFFSET], {BLOCK_OFFSET{1'b0}}};
  endfunction

  // Saturating increment for the 16-bit statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 16'd1;
    end
  endfunction

  // Queue storage and bookkeeping
  logic [WIDTH-1:0] addr_r [DEPTH];
  logic [DEPTH-1:0] live_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [OUT_W-1:0] out_r;
  logic [15:0]      acc_r;
  logic [15:0]      drop_r;

  // Per-cycle decisions
  logic [WIDTH-1:0] pf_blk_s;
  logic [WIDTH-1:0] dm_blk_s;
  logic [DEPTH-1:0] pf_match_s;
  logic [DEPTH-1:0] cancel_s;
  logic [DEPTH-1:0] live_next_s;
  logic             pf_hit_s;
  logic             handshake_s;
  logic             drop_s;
  logic             enq_s;
  logic             issue_s;
  logic             pop_s;
  logic             resp_s;
  logic             not_empty_s;
  logic             cap_ok_s;

  assign pf_blk_s    = blk(pf_addr_i);
  assign dm_blk_s    = blk(demand_addr_i);
  assign not_empty_s = (count_r != {CNT_W{1'b0}});
  assign cap_ok_s    = (out_r < OUT_W'(MAX_OUTSTANDING));

  // Ready comes only from registered occupancy so it never loops back from pf_valid_i.
  assign pf_ready_o = (count_r < CNT_W'(DEPTH)) && !rst;

  // The memory request is a pure function of registered state: it stays stable
  // until accepted because the head cannot be cancelled while offered and the
  // outstanding count can only fall while it is offered.
  assign mem_req_valid_o = not_empty_s && live_r[head_r] && cap_ok_s;

  // Present the head address only while the request is valid; zero otherwise.
  always_comb begin
    if (mem_req_valid_o) begin
      mem_req_addr_o = addr_r[head_r];
    end else begin
      mem_req_addr_o = {WIDTH{1'b0}};
    end
  end

  // Compare the incoming prefetch and the demand miss against every live entry.
  always_comb begin
    pf_match_s = {DEPTH{1'b0}};
    cancel_s   = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      pf_match_s[i] = live_r[i] && (addr_r[i] == pf_blk_s);
      // The head entry being offered to memory is protected from cancellation.
      cancel_s[i]   = demand_valid_i && live_r[i] && (addr_r[i] == dm_blk_s) &&
                      !((PTR_W'(i) == head_r) && mem_req_valid_o);
    end
  end

  assign pf_hit_s    = |pf_match_s;
  assign handshake_s = pf_valid_i && pf_ready_o;
  assign drop_s      = handshake_s &&
                       (pf_hit_s || (demand_valid_i && (pf_blk_s == dm_blk_s)));
  assign enq_s       = handshake_s && !drop_s;
  assign issue_s     = mem_req_valid_o && mem_req_ready_i;
  // A dead head leaves silently; a live head leaves only when issued.
  assign pop_s       = not_empty_s && (!live_r[head_r] || issue_s);
  // A fill with nothing outstanding belongs to a discarded request and is ignored.
  assign resp_s      = mem_resp_valid_i && (out_r != {OUT_W{1'b0}});

  // Next live flags: apply demand cancels, retire the popped head, mark a new tail.
  always_comb begin
    live_next_s = live_r & ~cancel_s;
    if (pop_s) begin
      live_next_s[head_r] = 1'b0;
    end else begin
      live_next_s[head_r] = live_next_s[head_r];
    end
    if (enq_s) begin
      live_next_s[tail_r] = 1'b1;
    end else begin
      live_next_s[tail_r] = live_next_s[tail_r];
    end
  end

  // Entry storage: live flags every cycle, the address only when enqueuing.
  always_ff @(posedge clk) begin
    if (rst) begin
      live_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      live_r <= live_next_s;
      if (enq_s) begin
        addr_r[tail_r] <= pf_blk_s;
      end
    end
  end

  // Head/tail pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
    end else begin
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      if (enq_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
    end
  end

  // Entry count, including cancelled entries still waiting to drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({enq_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Outstanding fill tracking; a simultaneous issue and fill cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= {OUT_W{1'b0}};
    end else begin
      case ({issue_s, resp_s})
        2'b10:   out_r <= out_r + OUT_W'(1);
        2'b01:   out_r <= out_r - OUT_W'(1);
        default: out_r <= out_r;
      endcase
    end
  end

  // Saturating statistics for accepted and dropped prefetches.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r  <= 16'h0000;
      drop_r <= 16'h0000;
    end else begin
      if (enq_s) begin
        acc_r <= sat_inc(acc_r);
      end
      if (drop_s) begin
        drop_r <= sat_inc(drop_r);
      end
    end
  end

  assign occupancy_o       = count_r;
  assign pf_accepted_cnt_o = acc_r;
  assign pf_dropped_cnt_o  = drop_r;

endmodule

// File: tb/tb_prefetch_request_queue.sv
// Directed bench for prefetch_request_queue. Expected memory issues are pushed
// into a scoreboard queue when the stimulus is applied; an independent monitor
// pops and compares on every issue handshake. Status outputs are compared
// against hand-computed values at points in the directed sequence.

module tb_prefetch_request_queue;

  localparam int WIDTH = 64;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] pf_addr;
  logic             pf_valid;
  logic             pf_ready;
  logic             demand_valid;
  logic [WIDTH-1:0] demand_addr;
  logic             mem_req_valid;
  logic [WIDTH-1:0] mem_req_addr;
  logic             mem_req_ready;
  logic             mem_resp_valid;
  logic [3:0]       occupancy;
  logic [15:0]      acc_cnt;
  logic [15:0]      drop_cnt;

  int total = 0;
  int bad = 0;
  int n_issued = 0;
  int base;
  logic [WIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  prefetch_request_queue #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BLOCK_OFFSET(6), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pf_addr_i(pf_addr),
    .pf_valid_i(pf_valid),
    .pf_ready_o(pf_ready),
    .demand_valid_i(demand_valid),
    .demand_addr_i(demand_addr),
    .mem_req_valid_o(mem_req_valid),
    .mem_req_addr_o(mem_req_addr),
    .mem_req_ready_i(mem_req_ready),
    .mem_resp_valid_i(mem_resp_valid),
    .occupancy_o(occupancy),
    .pf_accepted_cnt_o(acc_cnt),
    .pf_dropped_cnt_o(drop_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] a);
    pf_addr  = a;
    pf_valid = 1'b1;
    tick();
    pf_valid = 1'b0;
  endtask

  // Monitor: every issue handshake must match the next expected address.
  always @(negedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) begin
      n_issued++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL issue_unexpected: got 0x%0h expected none", mem_req_addr);
      end else begin
        chk("issue_order", mem_req_addr, exp_q.pop_front());
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pf_addr = '0; pf_valid = 1'b0; demand_valid = 1'b0;
    demand_addr = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    tick(); tick();
    chk("rst_ready_low", pf_ready, 1'b0);
    chk("rst_occ", occupancy, 4'd0);
    chk("rst_valid", mem_req_valid, 1'b0);
    chk("rst_addr", mem_req_addr, 64'h0);
    chk("rst_acc", acc_cnt, 16'd0);
    chk("rst_drop", drop_cnt, 16'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", pf_ready, 1'b1);

    // Basic flow
    mem_req_ready = 1'b1;
    exp_q.push_back(64'h1040);
    send(64'h1040);
    chk("t1_valid", mem_req_valid, 1'b1);
    chk("t1_addr", mem_req_addr, 64'h1040);
    chk("t1_acc", acc_cnt, 16'd1);
    chk("t1_occ", occupancy, 4'd1);
    tick();
    chk("t1_occ_after", occupancy, 4'd0);
    mem_resp_valid = 1'b1; tick(); mem_resp_valid = 1'b0;

    // Dedup within a block
    mem_req_ready = 1'b0;
    send(64'h2000);
    send(64'h203F);
    chk("t2_occ", occupancy, 4'd1);
    chk("t2_drop", drop_cnt, 16'd1);
    chk("t2_acc", acc_cnt, 16'd2);
    exp_q.push_back(64'h2000);
    mem_req_ready = 1'b1; tick();
    mem_resp_valid = 1'b1; tick(); mem_resp_valid = 1'b0;

    // Full, drain, refill across the pointer wrap
    mem_req_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pf_addr  = 64'h4000 + 64'(i) * 64'h40;
      pf_valid = 1'b1;
      chk("t3_ready", pf_ready, (i < 8) ? 1'b1 : 1'b0);
      if (i < 8) exp_q.push_back(pf_addr);
      tick();
    end
    pf_valid = 1'b0;
    chk("t3_occ_full", occupancy, 4'd8);
    chk("t3_ready_full", pf_ready, 1'b0);
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    repeat (10) tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    chk("t3_drained", occupancy, 4'd0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(64'h5000 + 64'(i) * 64'h40);
      send(64'h5000 + 64'(i) * 64'h40);
    end
    chk("t3_refill_occ", occupancy, 4'd8);
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    repeat (10) tick();
    mem_resp_valid = 1'b0;
    chk("t3_drained2", occupancy, 4'd0);
    chk("t3_acc", acc_cnt, 16'd18);

    // Demand cancel while the head is held by the outstanding cap
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(64'h6000 + 64'(i) * 64'h40);
      send(64'h6000 + 64'(i) * 64'h40);
    end
    tick(); tick();
    send(64'h3000); send(64'h3040); send(64'h3080);
    tick();
    exp_q.push_back(64'h3000);
    exp_q.push_back(64'h3080);
    chk("t4_occ", occupancy, 4'd3);
    chk("t4_stalled", mem_req_valid, 1'b0);
    demand_addr = 64'h3048; demand_valid = 1'b1; tick(); demand_valid = 1'b0;
    chk("t4_occ_cancel", occupancy, 4'd3);
    mem_resp_valid = 1'b1; tick(); mem_resp_valid = 1'b0;
    chk("t4_head_valid", mem_req_valid, 1'b1);
    chk("t4_head_addr", mem_req_addr, 64'h3000);
    tick(); tick();
    chk("t4_occ_after", occupancy, 4'd1);
    chk("t4_capped", mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1; tick(); mem_resp_valid = 1'b0;
    chk("t4_next_addr", mem_req_addr, 64'h3080);
    tick();
    chk("t4_occ_empty", occupancy, 4'd0);
    mem_resp_valid = 1'b1; repeat (4) tick(); mem_resp_valid = 1'b0;

    // Outstanding cap
    mem_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(64'h8000 + 64'(i) * 64'h40);
      send(64'h8000 + 64'(i) * 64'h40);
    end
    base = n_issued;
    mem_req_ready = 1'b1;
    repeat (8) tick();
    chk("t5_issued_cap", 64'(n_issued - base), 64'd4);
    chk("t5_capped", mem_req_valid, 1'b0);
    chk("t5_occ", occupancy, 4'd2);
    mem_resp_valid = 1'b1; tick(); mem_resp_valid = 1'b0;
    chk("t5_fifth_valid", mem_req_valid, 1'b1);
    chk("t5_fifth_addr", mem_req_addr, 64'h8100);
    mem_resp_valid = 1'b1; tick(); mem_resp_valid = 1'b0;
    chk("t5_sixth_valid", mem_req_valid, 1'b1);
    chk("t5_sixth_addr", mem_req_addr, 64'h8140);
    tick();
    exp_q.push_back(64'h8180);
    send(64'h8180);
    tick(); tick();
    chk("t5_cap_again", mem_req_valid, 1'b0);
    chk("t5_occ_one", occupancy, 4'd1);
    mem_resp_valid = 1'b1; repeat (5) tick(); mem_resp_valid = 1'b0;
    chk("t5_occ_empty", occupancy, 4'd0);

    // Reset mid-stream
    exp_q.push_back(64'h9000);
    exp_q.push_back(64'h9040);
    send(64'h9000); send(64'h9040);
    tick();
    mem_req_ready = 1'b0;
    send(64'h9080); send(64'h90C0); send(64'h9100);
    chk("t6_occ", occupancy, 4'd3);
    rst = 1'b1; tick();
    chk("t6_ready_in_rst", pf_ready, 1'b0);
    rst = 1'b0; #1;
    chk("t6_occ_rst", occupancy, 4'd0);
    chk("t6_valid_rst", mem_req_valid, 1'b0);
    chk("t6_addr_rst", mem_req_addr, 64'h0);
    chk("t6_acc_rst", acc_cnt, 16'd0);
    chk("t6_drop_rst", drop_cnt, 16'd0);
    chk("t6_ready", pf_ready, 1'b1);
    mem_resp_valid = 1'b1; tick(); mem_resp_valid = 1'b0;
    mem_req_ready = 1'b1;
    exp_q.push_back(64'hA000);
    send(64'hA000);
    chk("t6_issue_now", mem_req_valid, 1'b1);
    chk("t6_issue_addr", mem_req_addr, 64'hA000);
    tick();

    // Offered head survives a demand; same-cycle demand drops the request
    mem_req_ready = 1'b0;
    exp_q.push_back(64'hB000);
    send(64'hB000);
    chk("t7_valid", mem_req_valid, 1'b1);
    demand_addr = 64'hB000; demand_valid = 1'b1; tick(); demand_valid = 1'b0;
    chk("t7_head_kept", mem_req_valid, 1'b1);
    chk("t7_head_addr", mem_req_addr, 64'hB000);
    chk("t7_occ", occupancy, 4'd1);
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    chk("t7_occ_empty", occupancy, 4'd0);
    demand_addr = 64'hC020; demand_valid = 1'b1;
    send(64'hC000);
    demand_valid = 1'b0;
    tick();
    chk("t7_drop", drop_cnt, 16'd1);
    chk("t7_acc", acc_cnt, 16'd2);
    chk("t7_occ_drop", occupancy, 4'd0);

    repeat (3) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
